rijndael_inv_sbox_iter: RTL and testbench
=========================================

Name: rijndael_inv_sbox_iter

Overview:
- Sequential Rijndael inverse S-box: maps an S-box output byte back to its input byte, InvSbox(y) = inv(A^-1(y)).
- Computes the result arithmetically, with no ROM:
  - combinational inverse affine transform on accept;
  - GF(2^8) inversion as y^254 by iterative square-and-multiply;
  - field reduction polynomial 0x11B.
- Used as a decryption-side target for trace acquisition; its data-dependent register activity gives a multi-cycle leakage window.
- Valid/ready handshake on both sides.

Parameters:
- STEPS_PER_CYCLE, 1, exponent iterations per clock. Legal values 1, 2, 4, 8; any other value is an elaboration error. Compute latency = 8/STEPS_PER_CYCLE cycles.

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  in_data is valid
- in_ready  out  1  block can accept; high only in IDLE
- in_data  in  8  S-box output byte to invert
- out_valid  out  1  out_data is valid
- out_ready  in  1  downstream accepts out_data
- out_data  out  8  recovered S-box input byte
- busy  out  1  high in EXP and DONE

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE, out_valid=0, out_data=0x00, busy=0, in_ready=1 after the edge;
  - base, acc and step counter cleared;
  - rst has priority over all other events.
- Reset mid-operation: any in-flight computation is discarded and no out_valid is produced for it.
- States: IDLE, EXP, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid at an edge:
    - base <= A^-1(in_data); bit i = b[(i+2)%8] ^ b[(i+5)%8] ^ b[(i+7)%8] ^ 0x05[i];
    - acc <= 0x01, step <= 0, go to EXP.
- EXP:
  - in_ready=0.
  - Each cycle performs STEPS_PER_CYCLE iterations, MSB first over exponent 254 = 8'b11111110.
  - Iteration k (k=0..7): acc = acc^2, then acc = acc*base if bit (7-k) of 254 is 1.
  - All GF multiplies reduce modulo x^8+x^4+x^3+x+1.
  - After 8 total iterations: out_data <= acc, out_valid <= 1, go to DONE.
  - Iterations within one cycle are chained combinationally.
- DONE:
  - out_valid=1; out_data is held stable until the handshake completes.
  - out_valid & out_ready at an edge: out_valid <= 0, go to IDLE.
  - A new input is accepted no earlier than the following cycle; there is no pipelining.
- Zero input: A^-1(y)=0 when y=0x63. 0^254 evaluates to 0 with no special case, so InvSbox(0x63)=0x00.
- Latency: with the accept edge at N, out_valid is high after edge N + 8/STEPS_PER_CYCLE.
- Throughput: one result per 8/STEPS_PER_CYCLE + 2 cycles when out_ready is held high.
- in_data is sampled only at the accept edge; changes to it during EXP or DONE have no effect.
- out_ready while out_valid=0 is ignored.

Optional Feature:
- Macro: RIJNDAEL_INV_SBOX_TRIGGER_EN.
- Defined:
  - adds output port trig (1 bit, reset 0) for oscilloscope triggering;
  - trig is registered, high for exactly one cycle, in the first EXP cycle after each accept;
  - trig is cleared by rst.
- Undefined: port trig is absent. All other behaviour is unchanged.

Test Plan:
- Reset, then in_data=0x63 with in_valid=1, out_ready=1, STEPS_PER_CYCLE=1 -> out_valid rises exactly 8 cycles after accept, out_data=0x00.
- Single vectors:
  - 0x7C -> 0x01
  - 0x00 -> 0x52
  - 0x16 -> 0xFF
  - 0xFF -> 0x7D
  - 0x01 -> 0x09
- Sweep all 256 inputs for each of STEPS_PER_CYCLE 1, 2, 4, 8:
  - each result matches an inverse-S-box reference model;
  - the full round trip Sbox(InvSbox(y)) == y is checked;
  - latency is 8, 4, 2, 1 cycles respectively.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> out_data stable, in_ready=0 throughout, in_data changes ignored; release -> exactly one transfer, in_ready=1 on the next cycle.
- Assert rst in the third EXP cycle -> next cycle out_valid=0, busy=0, in_ready=1; no result is emitted for the aborted input; the next input 0x7C returns 0x01.
- With RIJNDAEL_INV_SBOX_TRIGGER_EN defined and back-to-back inputs -> trig is a one-cycle pulse per accept, located one cycle after the accept edge.

Source files
------------

// File: rtl/rijndael_inv_sbox_iter.sv
// rtl/rijndael_inv_sbox_iter.sv - ROM-less iterative Rijndael inverse S-box (inv affine, then y^254)
// Define RIJNDAEL_INV_SBOX_TRIGGER_EN to add the one-cycle trig output.
module rijndael_inv_sbox_iter #(
   parameter int STEPS_PER_CYCLE = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] in_data,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [7:0] out_data,
   output logic       busy
`ifdef RIJNDAEL_INV_SBOX_TRIGGER_EN
   ,
   output logic       trig
`endif
);
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_EXP  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;
   localparam logic [7:0] EXPONENT = 8'hFE;
   localparam logic [3:0] STEP_INC = 4'(STEPS_PER_CYCLE);

   generate
      if (STEPS_PER_CYCLE != 1 && STEPS_PER_CYCLE != 2 &&
          STEPS_PER_CYCLE != 4 && STEPS_PER_CYCLE != 8) begin : g_bad_steps
         $error("STEPS_PER_CYCLE must be 1, 2, 4 or 8");
      end
   endgenerate

   logic [1:0] state;
   logic [7:0] base;
   logic [7:0] acc;
   logic [3:0] step;
   logic [3:0] step_next;
   logic [7:0] chain;
   logic [2:0] k;

   // GF(2^8) multiply, reduction by x^8+x^4+x^3+x+1
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = x[7] ? ((x << 1) ^ 8'h1B) : (x << 1);
      end
      return p;
   endfunction

   function automatic logic [7:0] inv_affine(input logic [7:0] b);
      logic [7:0] r;
      for (int i = 0; i < 8; i++)
         r[i] = b[(i + 2) % 8] ^ b[(i + 5) % 8] ^ b[(i + 7) % 8];
      return r ^ 8'h05;
   endfunction

   assign step_next = step + STEP_INC;
   assign in_ready  = (state == S_IDLE);
   assign busy      = (state == S_EXP) || (state == S_DONE);

   // Square-and-multiply, MSB first; bit 0 of 254 is clear so the last step only squares
   always_comb begin
      chain = acc;
      k     = 3'd0;
      for (int j = 0; j < STEPS_PER_CYCLE; j++) begin
         k     = step[2:0] + 3'(j);
         chain = gf_mul(chain, chain);
         if (EXPONENT[3'd7 - k]) chain = gf_mul(chain, base);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         base      <= 8'h00;
         acc       <= 8'h00;
         step      <= 4'd0;
         out_valid <= 1'b0;
         out_data  <= 8'h00;
`ifdef RIJNDAEL_INV_SBOX_TRIGGER_EN
         trig      <= 1'b0;
`endif
      end else begin
`ifdef RIJNDAEL_INV_SBOX_TRIGGER_EN
         trig <= 1'b0;
`endif
         case (state)
            S_IDLE: begin
               if (in_valid) begin
                  base  <= inv_affine(in_data);
                  acc   <= 8'h01;
                  step  <= 4'd0;
                  state <= S_EXP;
`ifdef RIJNDAEL_INV_SBOX_TRIGGER_EN
                  trig  <= 1'b1;
`endif
               end
            end
            S_EXP: begin
               acc  <= chain;
               step <= step_next;
               if (step_next == 4'd8) begin
                  out_data  <= chain;
                  out_valid <= 1'b1;
                  state     <= S_DONE;
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_rijndael_inv_sbox_iter.sv
// tb/tb_rijndael_inv_sbox_iter.sv - scoreboard bench for rijndael_inv_sbox_iter, STEPS_PER_CYCLE 1/2/4/8
module tb_rijndael_inv_sbox_iter;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic [3:0] in_valid, in_ready, out_valid, out_ready, busy;
   logic [7:0] in_data [4];
   logic [7:0] out_data [4];
`ifdef RIJNDAEL_INV_SBOX_TRIGGER_EN
   logic [3:0] trig;
   logic [3:0] acc_prev = 4'b0;
`endif

   int compared = 0;
   int mismatched = 0;
   int cyc = 0;

   typedef struct {
      logic [7:0] y;
      logic [7:0] e;
      int lat;
      int acc_cyc;
      int g;
   } item_t;
   item_t q[$];

   logic [7:0] sbox_ref [256];
   logic [7:0] inv_ref [256];
   logic [3:0] prev_valid = 4'b0;

   for (genvar g = 0; g < 4; g++) begin : g_dut
      rijndael_inv_sbox_iter #(.STEPS_PER_CYCLE(1 << g)) u_dut (
         .clk(clk), .rst(rst),
         .in_valid(in_valid[g]), .in_ready(in_ready[g]), .in_data(in_data[g]),
         .out_valid(out_valid[g]), .out_ready(out_ready[g]), .out_data(out_data[g]),
         .busy(busy[g])
`ifdef RIJNDAEL_INV_SBOX_TRIGGER_EN
         , .trig(trig[g])
`endif
      );
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 0;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p ^= x;
         x = x[7] ? ((x << 1) ^ 8'h1B) : (x << 1);
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
      return (b << n) | (b >> (8 - n));
   endfunction

   // Scoreboard monitor: latency on rise, data every valid cycle, round trip on transfer
   always @(negedge clk) begin
      if (!rst) begin
         for (int g = 0; g < 4; g++) begin
            if (out_valid[g]) begin
               chk("in_ready_low_while_valid", 32'(in_ready[g]), 32'd0);
               if (q.size() == 0 || q[0].g != g) begin
                  compared++;
                  mismatched++;
                  $display("FAIL unexpected_output: dut %0d presented %02h with nothing expected", g, out_data[g]);
               end else begin
                  if (!prev_valid[g]) chk("latency", 32'(cyc - q[0].acc_cyc), 32'(q[0].lat));
                  chk("out_data", 32'(out_data[g]), 32'(q[0].e));
                  if (out_ready[g]) begin
                     chk("round_trip", 32'(sbox_ref[out_data[g]]), 32'(q[0].y));
                     void'(q.pop_front());
                  end
               end
            end
            prev_valid[g] = out_valid[g];
         end
      end else begin
         prev_valid = 4'b0;
      end
   end

`ifdef RIJNDAEL_INV_SBOX_TRIGGER_EN
   always @(negedge clk) begin
      for (int g = 0; g < 4; g++) begin
         if (!rst) chk("trig_pulse", 32'(trig[g]), 32'(acc_prev[g]));
         acc_prev[g] = in_valid[g] & in_ready[g] & ~rst;
      end
   end
`endif

   // Called at posedge+1; returns one step after the accept edge
   task automatic send(input int g, input logic [7:0] d, input logic [7:0] e, input bit push);
      int t;
      item_t it;
      t = 0;
      while (!in_ready[g] && t < 200) begin
         @(posedge clk); #1;
         t++;
      end
      if (t >= 200) chk("send_timeout", 32'(in_ready[g]), 32'd1);
      in_data[g] = d;
      in_valid[g] = 1'b1;
      @(posedge clk); #1;
      in_valid[g] = 1'b0;
      in_data[g] = 8'($urandom);
      if (push) begin
         it.y = d; it.e = e; it.lat = 8 >> g; it.acc_cyc = cyc; it.g = g;
         q.push_back(it);
      end
   endtask

   task automatic drain();
      int t;
      t = 0;
      while (q.size() != 0 && t < 300) begin
         @(posedge clk); #1;
         t++;
      end
      chk("drain_queue_empty", 32'(q.size()), 32'd0);
   endtask

   initial begin
      logic [7:0] inv;
      int t;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int c = 1; c < 256; c++)
            if (gmul(8'(x), 8'(c)) == 8'h01) inv = 8'(c);
         sbox_ref[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
      end
      for (int x = 0; x < 256; x++) inv_ref[sbox_ref[x]] = 8'(x);

      rst = 1'b1;
      in_valid = 4'b0;
      out_ready = 4'hF;
      for (int g = 0; g < 4; g++) in_data[g] = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      for (int g = 0; g < 4; g++) begin
         chk("reset_out_valid", 32'(out_valid[g]), 32'd0);
         chk("reset_out_data", 32'(out_data[g]), 32'h00);
         chk("reset_busy", 32'(busy[g]), 32'd0);
         chk("reset_in_ready", 32'(in_ready[g]), 32'd1);
      end
      rst = 1'b0;

      send(0, 8'h63, 8'h00, 1'b1);
      send(0, 8'h7C, 8'h01, 1'b1);
      send(0, 8'h00, 8'h52, 1'b1);
      send(0, 8'h16, 8'hFF, 1'b1);
      send(0, 8'hFF, 8'h7D, 1'b1);
      send(0, 8'h01, 8'h09, 1'b1);
      drain();

      for (int g = 0; g < 4; g++) begin
         for (int y = 0; y < 256; y++) send(g, 8'(y), inv_ref[y], 1'b1);
         drain();
      end

      // Backpressure on the S=1 instance
      out_ready[0] = 1'b0;
      send(0, 8'h16, 8'hFF, 1'b1);
      t = 0;
      while (!out_valid[0] && t < 50) begin
         @(posedge clk); #1;
         t++;
      end
      chk("bp_valid_seen", 32'(out_valid[0]), 32'd1);
      repeat (5) begin
         @(posedge clk); #1;
         in_data[0] = 8'($urandom);
         chk("bp_in_ready_low", 32'(in_ready[0]), 32'd0);
         chk("bp_valid_held", 32'(out_valid[0]), 32'd1);
         chk("bp_busy_high", 32'(busy[0]), 32'd1);
      end
      out_ready[0] = 1'b1;
      @(posedge clk); #1;
      chk("bp_valid_dropped", 32'(out_valid[0]), 32'd0);
      chk("bp_in_ready_back", 32'(in_ready[0]), 32'd1);
      chk("bp_one_transfer", 32'(q.size()), 32'd0);

      // Reset in the third EXP cycle discards the computation
      send(0, 8'h55, inv_ref[8'h55], 1'b0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("abort_busy_before_reset", 32'(busy[0]), 32'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("abort_out_valid", 32'(out_valid[0]), 32'd0);
      chk("abort_busy", 32'(busy[0]), 32'd0);
      chk("abort_in_ready", 32'(in_ready[0]), 32'd1);
      rst = 1'b0;
      repeat (12) begin
         @(posedge clk); #1;
         chk("abort_no_result", 32'(out_valid[0]), 32'd0);
      end
      send(0, 8'h7C, 8'h01, 1'b1);
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
